// File: rtl/axi4lite_slice_pkg.sv
// Shared types and payload-width helpers for the AXI4-Lite register slice.
package axi4lite_slice_pkg;

  typedef enum logic [1:0] {
    SLICE_BYPASS = 2'd0,
    SLICE_FWD    = 2'd1,
    SLICE_FULL   = 2'd2
  } slice_mode_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  function automatic int ax_payload_width(input int addr_width);
    return addr_width + 32'd3;
  endfunction

  function automatic int w_payload_width(input int data_width);
    return data_width + data_width / 32'd8;
  endfunction

  function automatic int b_payload_width();
    return 32'd2;
  endfunction

  function automatic int r_payload_width(input int data_width);
    return data_width + 32'd2;
  endfunction

endpackage

// File: rtl/axi4lite_intf.sv
// AXI4-Lite bundle with master/slave views.
interface axi4lite_intf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic                      ACLK;
  logic                      ARESETn;
  logic [ADDR_WIDTH-1:0]     AWADDR;
  logic [2:0]                AWPROT;
  logic                      AWVALID;
  logic                      AWREADY;
  logic [DATA_WIDTH-1:0]     WDATA;
  logic [DATA_WIDTH/8-1:0]   WSTRB;
  logic                      WVALID;
  logic                      WREADY;
  logic [1:0]                BRESP;
  logic                      BVALID;
  logic                      BREADY;
  logic [ADDR_WIDTH-1:0]     ARADDR;
  logic [2:0]                ARPROT;
  logic                      ARVALID;
  logic                      ARREADY;
  logic [DATA_WIDTH-1:0]     RDATA;
  logic [1:0]                RRESP;
  logic                      RVALID;
  logic                      RREADY;

  modport master (
    input  ACLK, ARESETn,
    output AWADDR, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input  BRESP, BVALID, output BREADY,
    output ARADDR, ARPROT, ARVALID, input ARREADY,
    input  RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input  ACLK, ARESETn,
    input  AWADDR, AWPROT, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input  ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );
endinterface

// File: rtl/axi4lite_slice_chan.sv
// One valid/ready channel stage: bypass, forward-registered, or two-entry skid buffer.
module axi4lite_slice_chan
  import axi4lite_slice_pkg::*;
#(
  parameter int          WIDTH = 32,
  parameter slice_mode_e MODE  = SLICE_FULL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  if (MODE == SLICE_BYPASS) begin : g_bypass
    logic unused_clk_s;
    assign unused_clk_s = clk ^ rst_n;
    assign out_valid    = in_valid;
    assign out_data     = in_data;
    assign in_ready     = out_ready;
  end else if (MODE == SLICE_FWD) begin : g_fwd
    logic             valid_r;
    logic [WIDTH-1:0] data_r;

    assign in_ready  = !valid_r || out_ready;
    assign out_valid = valid_r;
    assign out_data  = data_r;

    // Output register: refill on accept, drain when downstream takes the beat.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_r <= 1'b0;
        data_r  <= {WIDTH{1'b0}};
      end else if (in_valid && in_ready) begin
        valid_r <= 1'b1;
        data_r  <= in_data;
      end else if (out_ready) begin
        valid_r <= 1'b0;
      end
    end
  end else begin : g_full
    skid_state_e      state_r, state_s;
    logic             ready_r;
    logic [WIDTH-1:0] main_r, skid_r;
    logic             in_acc_s, load_main_s, load_skid_s, skid_to_main_s;

    assign in_ready  = ready_r;
    assign out_valid = (state_r != ST_EMPTY);
    assign out_data  = main_r;

    // Occupancy transitions and which payload register loads this cycle.
    always_comb begin
      state_s        = state_r;
      load_main_s    = 1'b0;
      load_skid_s    = 1'b0;
      skid_to_main_s = 1'b0;
      in_acc_s       = in_valid && ready_r;
      case (state_r)
        ST_EMPTY: begin
          if (in_acc_s) begin
            state_s     = ST_ONE;
            load_main_s = 1'b1;
          end else begin
            state_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_acc_s && out_ready) begin
            load_main_s = 1'b1;
          end else if (in_acc_s) begin
            state_s     = ST_TWO;
            load_skid_s = 1'b1;
          end else if (out_ready) begin
            state_s = ST_EMPTY;
          end else begin
            state_s = ST_ONE;
          end
        end
        ST_TWO: begin
          if (out_ready) begin
            state_s        = ST_ONE;
            skid_to_main_s = 1'b1;
          end else begin
            state_s = ST_TWO;
          end
        end
        default: state_s = ST_EMPTY;
      endcase
    end

    // State, registered ready (no path from out_ready) and payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_r <= ST_EMPTY;
        ready_r <= 1'b0;
        main_r  <= {WIDTH{1'b0}};
        skid_r  <= {WIDTH{1'b0}};
      end else begin
        state_r <= state_s;
        ready_r <= (state_s != ST_TWO);
        if (load_main_s) begin
          main_r <= in_data;
        end else if (skid_to_main_s) begin
          main_r <= skid_r;
        end
        if (load_skid_s) begin
          skid_r <= in_data;
        end
      end
    end
  end

endmodule

// File: rtl/axi4lite_reg_slice.sv
// AXI4-Lite register slice: one independently configured stage per channel.
module axi4lite_reg_slice
  import axi4lite_slice_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 32,
  parameter slice_mode_e AW_MODE    = SLICE_FULL,
  parameter slice_mode_e W_MODE     = SLICE_FULL,
  parameter slice_mode_e B_MODE     = SLICE_FWD,
  parameter slice_mode_e AR_MODE    = SLICE_FULL,
  parameter slice_mode_e R_MODE     = SLICE_FULL
) (
  input  logic         ACLK,
  input  logic         ARESETn,
  axi4lite_intf.slave  s_axil,
  axi4lite_intf.master m_axil
);

  localparam int AX_W = ax_payload_width(ADDR_WIDTH);
  localparam int W_W  = w_payload_width(DATA_WIDTH);
  localparam int B_W  = b_payload_width();
  localparam int R_W  = r_payload_width(DATA_WIDTH);

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
    $error("axi4lite_reg_slice: DATA_WIDTH must be 32 or 64");
  end

  logic [AX_W-1:0] aw_in_s, aw_out_s, ar_in_s, ar_out_s;
  logic [W_W-1:0]  w_in_s, w_out_s;
  logic [B_W-1:0]  b_in_s, b_out_s;
  logic [R_W-1:0]  r_in_s, r_out_s;

  assign aw_in_s = {s_axil.AWADDR, s_axil.AWPROT};
  assign {m_axil.AWADDR, m_axil.AWPROT} = aw_out_s;
  assign w_in_s  = {s_axil.WDATA, s_axil.WSTRB};
  assign {m_axil.WDATA, m_axil.WSTRB} = w_out_s;
  assign ar_in_s = {s_axil.ARADDR, s_axil.ARPROT};
  assign {m_axil.ARADDR, m_axil.ARPROT} = ar_out_s;
  // Response channels run against the request direction: m side feeds s side.
  assign b_in_s  = m_axil.BRESP;
  assign s_axil.BRESP = b_out_s;
  assign r_in_s  = {m_axil.RDATA, m_axil.RRESP};
  assign {s_axil.RDATA, s_axil.RRESP} = r_out_s;

  axi4lite_slice_chan #(.WIDTH(AX_W), .MODE(AW_MODE)) u_aw (
    .clk(ACLK), .rst_n(ARESETn),
    .in_valid(s_axil.AWVALID), .in_ready(s_axil.AWREADY), .in_data(aw_in_s),
    .out_valid(m_axil.AWVALID), .out_ready(m_axil.AWREADY), .out_data(aw_out_s)
  );

  axi4lite_slice_chan #(.WIDTH(W_W), .MODE(W_MODE)) u_w (
    .clk(ACLK), .rst_n(ARESETn),
    .in_valid(s_axil.WVALID), .in_ready(s_axil.WREADY), .in_data(w_in_s),
    .out_valid(m_axil.WVALID), .out_ready(m_axil.WREADY), .out_data(w_out_s)
  );

  axi4lite_slice_chan #(.WIDTH(B_W), .MODE(B_MODE)) u_b (
    .clk(ACLK), .rst_n(ARESETn),
    .in_valid(m_axil.BVALID), .in_ready(m_axil.BREADY), .in_data(b_in_s),
    .out_valid(s_axil.BVALID), .out_ready(s_axil.BREADY), .out_data(b_out_s)
  );

  axi4lite_slice_chan #(.WIDTH(AX_W), .MODE(AR_MODE)) u_ar (
    .clk(ACLK), .rst_n(ARESETn),
    .in_valid(s_axil.ARVALID), .in_ready(s_axil.ARREADY), .in_data(ar_in_s),
    .out_valid(m_axil.ARVALID), .out_ready(m_axil.ARREADY), .out_data(ar_out_s)
  );

  axi4lite_slice_chan #(.WIDTH(R_W), .MODE(R_MODE)) u_r (
    .clk(ACLK), .rst_n(ARESETn),
    .in_valid(m_axil.RVALID), .in_ready(m_axil.RREADY), .in_data(r_in_s),
    .out_valid(s_axil.RVALID), .out_ready(s_axil.RREADY), .out_data(r_out_s)
  );

endmodule

// File: tb/tb_axi4lite_reg_slice.sv
// Bench for axi4lite_reg_slice: directed scenarios plus randomized traffic against a queue model.
module tb_axi4lite_reg_slice;
  import axi4lite_slice_pkg::*;

  localparam int NCH = 5;
  localparam int BEATS = 10000;
  localparam int RND_LIMIT = 60000;
  // Channel order: AW, W, B, AR, R
  localparam slice_mode_e MD [NCH] = '{SLICE_FULL, SLICE_FULL, SLICE_FWD, SLICE_FWD, SLICE_BYPASS};
  localparam int CW [NCH] = '{35, 72, 2, 35, 66};

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   edges;

  logic [4:0]  in_valid, in_ready, out_valid, out_ready, rdy_set, in_hs, prev_stall;
  logic [71:0] in_data [NCH];
  logic [71:0] out_data [NCH];
  logic [71:0] prev_data [NCH];
  logic [71:0] src_q [NCH][$];
  logic [71:0] exp_q [NCH][$];
  int          out_count [NCH];

  axi4lite_intf #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) s_if ();
  axi4lite_intf #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) m_if ();

  axi4lite_reg_slice #(
    .DATA_WIDTH(64), .ADDR_WIDTH(32),
    .AW_MODE(SLICE_FULL), .W_MODE(SLICE_FULL), .B_MODE(SLICE_FWD),
    .AR_MODE(SLICE_FWD), .R_MODE(SLICE_BYPASS)
  ) dut (
    .ACLK(clk), .ARESETn(rst_n), .s_axil(s_if), .m_axil(m_if)
  );

  assign s_if.ACLK = clk;
  assign m_if.ACLK = clk;
  assign s_if.ARESETn = rst_n;
  assign m_if.ARESETn = rst_n;

  assign s_if.AWVALID = in_valid[0];
  assign {s_if.AWADDR, s_if.AWPROT} = in_data[0][34:0];
  assign in_ready[0] = s_if.AWREADY;
  assign out_valid[0] = m_if.AWVALID;
  assign out_data[0] = 72'({m_if.AWADDR, m_if.AWPROT});
  assign m_if.AWREADY = out_ready[0];

  assign s_if.WVALID = in_valid[1];
  assign {s_if.WDATA, s_if.WSTRB} = in_data[1];
  assign in_ready[1] = s_if.WREADY;
  assign out_valid[1] = m_if.WVALID;
  assign out_data[1] = {m_if.WDATA, m_if.WSTRB};
  assign m_if.WREADY = out_ready[1];

  assign m_if.BVALID = in_valid[2];
  assign m_if.BRESP = in_data[2][1:0];
  assign in_ready[2] = m_if.BREADY;
  assign out_valid[2] = s_if.BVALID;
  assign out_data[2] = 72'(s_if.BRESP);
  assign s_if.BREADY = out_ready[2];

  assign s_if.ARVALID = in_valid[3];
  assign {s_if.ARADDR, s_if.ARPROT} = in_data[3][34:0];
  assign in_ready[3] = s_if.ARREADY;
  assign out_valid[3] = m_if.ARVALID;
  assign out_data[3] = 72'({m_if.ARADDR, m_if.ARPROT});
  assign m_if.ARREADY = out_ready[3];

  assign m_if.RVALID = in_valid[4];
  assign {m_if.RDATA, m_if.RRESP} = in_data[4][65:0];
  assign in_ready[4] = m_if.RREADY;
  assign out_valid[4] = s_if.RVALID;
  assign out_data[4] = 72'({s_if.RDATA, s_if.RRESP});
  assign s_if.RREADY = out_ready[4];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edges seen since reset release; a FULL channel may only accept after the first.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else if (edges < 4) edges <= edges + 1;
  end

  task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic string tg(input string n, input int c);
    return $sformatf("%s_ch%0d", n, c);
  endfunction

  function automatic logic [71:0] rand_beat(input int c);
    logic [95:0] r;
    logic [71:0] one;
    one = 72'd1;
    r = {$urandom, $urandom, $urandom};
    return r[71:0] & ((one << CW[c]) - one);
  endfunction

  // Reference: each channel is an in-order queue; occupancy = accepted minus delivered.
  task automatic tick_check();
    logic ih, oh, exp_rdy;
    int occ;
    #1;
    for (int c = 0; c < NCH; c++) begin
      occ = exp_q[c].size();
      if (MD[c] == SLICE_BYPASS) begin
        check_eq(tg("byp_vld", c), 72'(out_valid[c]), 72'(in_valid[c]));
        check_eq(tg("byp_rdy", c), 72'(in_ready[c]), 72'(out_ready[c]));
        if (in_valid[c]) check_eq(tg("byp_data", c), out_data[c], in_data[c]);
      end else begin
        check_eq(tg("out_vld", c), 72'(out_valid[c]), 72'(occ > 0));
        if (MD[c] == SLICE_FWD) exp_rdy = (occ == 0) || out_ready[c];
        else exp_rdy = (occ < 2) && (edges > 0);
        check_eq(tg("in_rdy", c), 72'(in_ready[c]), 72'(exp_rdy));
      end
      if (prev_stall[c]) begin
        check_eq(tg("stall_vld", c), 72'(out_valid[c]), 72'd1);
        check_eq(tg("stall_data", c), out_data[c], prev_data[c]);
      end
      ih = in_valid[c] && in_ready[c];
      oh = out_valid[c] && out_ready[c];
      if (ih) exp_q[c].push_back(in_data[c]);
      if (oh) begin
        check_eq(tg("beat_avail", c), 72'(exp_q[c].size() != 0), 72'd1);
        if (exp_q[c].size() != 0) check_eq(tg("order", c), out_data[c], exp_q[c].pop_front());
        out_count[c]++;
      end
      in_hs[c] = ih;
      prev_stall[c] = out_valid[c] && !out_ready[c];
      prev_data[c] = out_data[c];
    end
  endtask

  task automatic run_cycle(input int vld_pct, input logic rnd_rdy);
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      if (!(in_valid[c] && !in_hs[c])) begin
        if (src_q[c].size() != 0 && $urandom_range(99) < vld_pct) begin
          in_valid[c] = 1'b1;
          in_data[c] = src_q[c].pop_front();
        end else begin
          in_valid[c] = 1'b0;
          in_data[c] = rand_beat(c);
        end
      end
      out_ready[c] = rnd_rdy ? 1'($urandom_range(1)) : rdy_set[c];
    end
    tick_check();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 5'b0;
    out_ready = 5'b0;
    in_hs = 5'b0;
    prev_stall = 5'b0;
    for (int c = 0; c < NCH; c++) begin
      in_data[c] = 72'd0;
      src_q[c].delete();
      exp_q[c].delete();
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_aw_rdy_pre_edge", 72'(in_ready[0]), 72'd0);
    check_eq("rst_w_rdy_pre_edge", 72'(in_ready[1]), 72'd0);
    check_eq("rst_vld", 72'(out_valid[3:0]), 72'd0);
  endtask

  initial begin
    int base;
    int cyc;
    int left;
    total = 0;
    bad = 0;
    for (int c = 0; c < NCH; c++) out_count[c] = 0;
    do_reset();

    // AW streaming at full rate
    rdy_set = 5'b11111;
    for (int i = 0; i < 8; i++) src_q[0].push_back(72'(i * 4) << 3);
    base = out_count[0];
    run_cycle(100, 1'b0);
    check_eq("aw_lat_first", 72'(out_valid[0]), 72'd0);
    run_cycle(100, 1'b0);
    check_eq("aw_first_out", out_data[0], 72'd0);
    for (int i = 0; i < 7; i++) run_cycle(100, 1'b0);
    check_eq("aw_stream_cnt", 72'(out_count[0] - base), 72'd8);

    // AW skid fills to two and back-pressures
    rdy_set[0] = 1'b0;
    base = out_count[0];
    src_q[0].push_back(72'h100 << 3);
    src_q[0].push_back(72'h104 << 3);
    src_q[0].push_back(72'h108 << 3);
    repeat (3) run_cycle(100, 1'b0);
    check_eq("aw_skid_full_rdy", 72'(in_ready[0]), 72'd0);
    check_eq("aw_skid_head", out_data[0], 72'h100 << 3);
    repeat (2) run_cycle(100, 1'b0);
    rdy_set[0] = 1'b1;
    repeat (6) run_cycle(100, 1'b0);
    check_eq("aw_skid_cnt", 72'(out_count[0] - base), 72'd3);

    // B forward stage under a stalling sink
    base = out_count[2];
    src_q[2].push_back(72'd2);
    run_cycle(100, 1'b0);
    check_eq("b_lat", 72'(out_valid[2]), 72'd0);
    rdy_set[2] = 1'b0;
    run_cycle(100, 1'b0);
    check_eq("b_stall_vld", 72'(out_valid[2]), 72'd1);
    check_eq("b_stall_resp", out_data[2], 72'd2);
    rdy_set[2] = 1'b1;
    run_cycle(100, 1'b0);
    check_eq("b_deliver_resp", out_data[2], 72'd2);
    run_cycle(100, 1'b0);
    check_eq("b_once_vld", 72'(out_valid[2]), 72'd0);
    check_eq("b_once_cnt", 72'(out_count[2] - base), 72'd1);

    // R bypass is zero-latency with ready passthrough
    base = out_count[4];
    rdy_set[4] = 1'b0;
    src_q[4].push_back(72'hDEADBEEF << 2);
    run_cycle(100, 1'b0);
    check_eq("r_byp_vld", 72'(out_valid[4]), 72'd1);
    check_eq("r_byp_data", out_data[4], 72'hDEADBEEF << 2);
    check_eq("r_byp_rdy0", 72'(in_ready[4]), 72'd0);
    rdy_set[4] = 1'b1;
    run_cycle(100, 1'b0);
    check_eq("r_byp_rdy1", 72'(in_ready[4]), 72'd1);
    check_eq("r_byp_cnt", 72'(out_count[4] - base), 72'd1);

    // Reset while W holds two beats
    rdy_set[1] = 1'b0;
    src_q[1].push_back(rand_beat(1));
    src_q[1].push_back(rand_beat(1));
    src_q[1].push_back(rand_beat(1));
    repeat (3) run_cycle(100, 1'b0);
    check_eq("w_two_rdy", 72'(in_ready[1]), 72'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_async_vld", 72'(out_valid[3:0]), 72'd0);
    check_eq("rst_async_wrdy", 72'(in_ready[1]), 72'd0);
    do_reset();
    rdy_set = 5'b11111;
    base = out_count[1];
    run_cycle(100, 1'b0);
    check_eq("w_rdy_after_rst", 72'(in_ready[1]), 72'd1);
    repeat (3) run_cycle(100, 1'b0);
    check_eq("w_no_stale", 72'(out_count[1] - base), 72'd0);

    // Randomized traffic on all channels
    do_reset();
    for (int c = 0; c < NCH; c++) begin
      out_count[c] = 0;
      for (int i = 0; i < BEATS; i++) src_q[c].push_back(rand_beat(c));
    end
    cyc = 0;
    left = 1;
    while (left != 0 && cyc < RND_LIMIT && bad <= 100) begin
      run_cycle(70, 1'b1);
      cyc++;
      left = 0;
      for (int c = 0; c < NCH; c++) left += src_q[c].size() + exp_q[c].size() + int'(in_valid[c]);
    end
    check_eq("rnd_in_budget", 72'(cyc < RND_LIMIT), 72'd1);
    for (int c = 0; c < NCH; c++) check_eq(tg("rnd_cnt", c), 72'(out_count[c]), 72'(BEATS));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4lite_reg_slice.md
# axi4lite_reg_slice

Parametrised AXI4-Lite register slice inserted between an upstream master and a downstream slave (e.g. between the bus decoder and a distant register block) to break timing paths. Each of the five channels gets its own independently selected mode: combinational bypass, forward-registered, or fully registered skid buffer. Transactions pass through unchanged and in order, and the slice is transparent to protocol semantics.

## Interface
Parameters:
- DATA_WIDTH, 32: AXI4-Lite data width (32 or 64); WSTRB width is DATA_WIDTH/8.
- ADDR_WIDTH, 32: address width.
- AW_MODE, SLICE_FULL: AW channel mode (slice_mode_e).
- W_MODE, SLICE_FULL: W channel mode.
- B_MODE, SLICE_FWD: B channel mode.
- AR_MODE, SLICE_FULL: AR channel mode.
- R_MODE, SLICE_FULL: R channel mode.

Ports:
- ACLK  input  1  sole clock; all state on rising edge.
- ARESETn  input  1  asynchronous, active-low reset.
- s_axil  axi4lite_intf.slave  —  upstream side; its ACLK/ARESETn members are not read.
- m_axil  axi4lite_intf.master  —  downstream side; its ACLK/ARESETn members are not read.

## Operation
- Channel payloads: AW/AR = {ADDR, PROT} (ADDR_WIDTH+3); W = {DATA, STRB} (DATA_WIDTH*9/8); B = RESP (2); R = {DATA, RESP} (DATA_WIDTH+2).
- Forward channels (AW, W, AR) flow s_axil→m_axil; reverse channels (B, R) flow m_axil→s_axil.
- Channels are fully independent; no AW/W pairing or outstanding-count tracking.
- SLICE_BYPASS: out_valid=in_valid, out_data=in_data, in_ready=out_ready; zero registers.
- SLICE_FWD: valid/data registered; in_ready = !out_valid_q || out_ready (combinational). Load on in_valid && in_ready.
- SLICE_FULL: two-entry skid. Main register drives output; skid register captures a beat accepted while the output stalls. in_ready is a register output = skid empty. States: EMPTY (main empty), ONE (main valid), TWO (main+skid valid, in_ready=0).
  - EMPTY: in beat → ONE.
  - ONE: in only → TWO if out stalled, stay ONE if out_ready; out only → EMPTY; both → ONE with new data.
  - TWO: out_ready → ONE, skid moves to main, in_ready rises next edge.
- Output payload is held stable while out_valid && !out_ready (AXI rule); payload registers load only on accept.
- No beat is dropped, duplicated or reordered in any mode.

## Timing
- Latency in→out: BYPASS 0 cycles, FWD and FULL 1 cycle.
- Throughput: 1 beat/cycle in every mode under continuous out_ready.
- FULL: in_ready has no combinational path from out_ready; FWD: out_valid and payload have no combinational path from in side.
- Reset (ARESETn low, asynchronous): all registered valid outputs 0, all registered payloads 0, FULL in_ready 0. FULL in_ready rises on the first ACLK edge after ARESETn deasserts. Bypassed channels follow their inputs combinationally.
- Reset mid-transfer: in-flight beats are discarded; no partial beat is emitted afterwards.
- Simultaneous accept on both sides in FULL/ONE: output updates to the new beat, state unchanged.

## Structure
- Package axi4lite_slice_pkg: typedef enum slice_mode_e {SLICE_BYPASS, SLICE_FWD, SLICE_FULL}; payload-width helper functions per channel.
- Sub-module axi4lite_slice_chan (#WIDTH, #MODE; in_valid/in_ready/in_data, out_valid/out_ready/out_data) implements one channel. The top packs and unpacks payloads and instantiates it five times.
- Top asserts DATA_WIDTH ∈ {32,64} at elaboration.

## Test plan
- All FULL, m_axil ready tied 1, stream 8 AW beats addr 0x0,0x4…0x1C → m_axil AWVALID one cycle after each, same order, 8 beats in 8 cycles.
- FULL AW, hold m_axil AWREADY=0 while pushing 3 beats 0x100,0x104,0x108 → 2 accepted, s_axil AWREADY low the cycle after the 2nd; release → 0x100,0x104,0x108 out, none lost.
- FWD B, M returns BRESP=2'b10 while s BREADY toggles 1,0,1 → BRESP stable during stall, delivered once, 1 cycle late.
- BYPASS R, RDATA=0xDEADBEEF same-cycle visible at s_axil → zero-cycle latency, ready passthrough.
- Assert ARESETn low while FULL W holds 2 beats → all VALIDs 0 immediately, WREADY 0; after release WREADY=1 next edge, no stale beat emitted.
- Randomised valid/ready on all 5 channels, DATA_WIDTH=64, 10k beats per channel → scoreboard exact in-order match, payload never changes during a stall.
